fetch_ctrl: RTL

Instruction-fetch sequencer that drives the combinational instruction memory of the 9-bit core. It owns the program counter and walks it through instruction memory after a start pulse, registering each fetched word for decode. It applies branch redirects and stalls from the datapath, and stops when it fetches the halt word. It sits between the instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_pc.sv | 32 +++
 rtl/fetch_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default geometry for the 9-bit core instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned FETCH_AW = 5;
  localparam int unsigned FETCH_IW = 9;
  localparam int unsigned FETCH_CW = 16;
  localparam logic [FETCH_IW-1:0] FETCH_HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALTED
  } state_e;

  // Next-PC selection handed from the FSM to the PC register.
  typedef enum logic [1:0] {
    PC_HOLD,
    PC_ZERO,
    PC_LOAD,
    PC_INC
  } pc_op_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with hold / zero / load-target / increment (wrapping) next-PC mux.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int unsigned AW = FETCH_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  pc_op_e        op,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_d;

  always_comb begin
    pc_d = pc;
    case (op)
      PC_HOLD: pc_d = pc;
      PC_ZERO: pc_d = '0;
      PC_LOAD: pc_d = target;
      PC_INC:  pc_d = pc + AW'(1);
      default: pc_d = pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= pc_d;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: walks the PC through instruction memory, registers issued words,
// applies branch redirects and stalls, and stops on the halt word.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned   AW         = FETCH_AW,
  parameter int unsigned   IW         = FETCH_IW,
  parameter logic [IW-1:0] HALT_INSTR = IW'(FETCH_HALT_INSTR),
  parameter int unsigned   CW         = FETCH_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_en,
  input  logic [AW-1:0] branch_target,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] instr_count
);

  state_e        state_q, state_d;
  pc_op_e        pc_op;
  logic [IW-1:0] instr_d;
  logic          valid_d;
  logic [CW-1:0] count_d;

  fetch_pc #(.AW(AW)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .op     (pc_op),
    .target (branch_target),
    .pc     (pc)
  );

  assign imem_addr = pc;

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    pc_op   = PC_HOLD;
    instr_d = instr;
    valid_d = instr_valid;
    count_d = instr_count;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_op   = PC_ZERO;
          count_d = '0;
          valid_d = 1'b0;
        end
      end
      FETCH: begin
        // Stall outranks a pending branch; the requester keeps branch_en up until it drops.
        if (stall) begin
          pc_op = PC_HOLD;
        end else if (branch_en) begin
          pc_op   = PC_LOAD;
          valid_d = 1'b0;
        end else if (imem_data == HALT_INSTR) begin
          valid_d = 1'b0;
          state_d = HALTED;
        end else begin
          instr_d = imem_data;
          valid_d = 1'b1;
          pc_op   = PC_INC;
          if (instr_count != '1) count_d = instr_count + CW'(1);
        end
      end
      HALTED: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = FETCH;
          pc_op   = PC_ZERO;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      instr       <= '0;
      instr_valid <= 1'b0;
      instr_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
      instr_count <= count_d;
      busy        <= (state_d == FETCH);
      done        <= (state_d == HALTED);
    end
  end

endmodule
